vector_stream_tx: RTL and testbench



---
 rtl/vector_stream_tx.sv | 145 ++++++++++++++
 tb/tb_vector_stream_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : vector_stream_tx
//  Brief    : Serialises one packed int8 vector onto a narrow valid/ready
//             stream and reports the signed argmax once per vector.
//  Revision : 1.0
// ============================================================================
module vector_stream_tx #(
    parameter  int VEC_SIZE   = 256,
    parameter  int DATA_WIDTH = 8,
    localparam int IDX_W      = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [VEC_SIZE*DATA_WIDTH-1:0] s_vec,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [IDX_W-1:0]               m_index,
    output logic                           m_last,
    output logic                           argmax_valid,
    output logic [IDX_W-1:0]               argmax_idx,
    output logic [DATA_WIDTH-1:0]          argmax_val
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(VEC_SIZE - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    state_t                         state_q;
    logic [IDX_W-1:0]               cnt_q;
    logic [VEC_SIZE*DATA_WIDTH-1:0] vec_q;
    logic                           s_ready_q;
    logic                           m_valid_q;
    logic                           m_last_q;
    logic [DATA_WIDTH-1:0]          max_val_q;
    logic [IDX_W-1:0]               max_idx_q;
    logic                           argmax_valid_q;
    logic [IDX_W-1:0]               argmax_idx_q;
    logic [DATA_WIDTH-1:0]          argmax_val_q;

    logic [DATA_WIDTH-1:0]          w_elem [VEC_SIZE];
    logic [DATA_WIDTH-1:0]          w_cur;
    logic                           w_xfer;
    logic                           w_take;
    logic                           w_cnt_is_last;
    logic [IDX_W-1:0]               cnt_d;
    logic [DATA_WIDTH-1:0]          max_val_d;
    logic [IDX_W-1:0]               max_idx_d;

    generate
        for (genvar k = 0; k < VEC_SIZE; k++) begin : g_unpack
            assign w_elem[k] = vec_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_cur         = w_elem[cnt_q];
    assign w_xfer        = m_valid_q & m_ready;
    assign w_cnt_is_last = (cnt_q == c_LAST_IDX);
    assign cnt_d         = cnt_q + c_IDX_ONE;

    // Element 0 always seeds the running max; later ones must be strictly
    // greater so ties keep the lowest index.
    assign w_take    = (cnt_q == '0) || ($signed(w_cur) > $signed(max_val_q));
    assign max_val_d = w_take ? w_cur : max_val_q;
    assign max_idx_d = w_take ? cnt_q : max_idx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            vec_q          <= '0;
            s_ready_q      <= 1'b1;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            max_val_q      <= '0;
            max_idx_q      <= '0;
            argmax_valid_q <= 1'b0;
            argmax_idx_q   <= '0;
            argmax_val_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid && s_ready_q) begin
                        vec_q     <= s_vec;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b0;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (c_LAST_IDX == '0);
                        state_q   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        max_val_q <= max_val_d;
                        max_idx_q <= max_idx_d;
                        if (w_cnt_is_last) begin
                            // Publish the final max directly so the result
                            // includes any update from the last element.
                            m_valid_q      <= 1'b0;
                            m_last_q       <= 1'b0;
                            argmax_valid_q <= 1'b1;
                            argmax_idx_q   <= max_idx_d;
                            argmax_val_q   <= max_val_d;
                            state_q        <= ST_RESULT;
                        end else begin
                            cnt_q    <= cnt_d;
                            m_last_q <= (cnt_d == c_LAST_IDX);
                        end
                    end
                end
                ST_RESULT: begin
                    argmax_valid_q <= 1'b0;
                    s_ready_q      <= 1'b1;
                    state_q        <= ST_IDLE;
                end
                default: begin
                    m_valid_q      <= 1'b0;
                    m_last_q       <= 1'b0;
                    argmax_valid_q <= 1'b0;
                    s_ready_q      <= 1'b1;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign m_valid      = m_valid_q;
    assign m_data       = w_cur;
    assign m_index      = cnt_q;
    assign m_last       = m_last_q;
    assign argmax_valid = argmax_valid_q;
    assign argmax_idx   = argmax_idx_q;
    assign argmax_val   = argmax_val_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_stream_tx
//  Brief    : Self-checking bench for vector_stream_tx with VEC_SIZE=4.
//  Revision : 1.0
// ============================================================================
module tb_vector_stream_tx;

    localparam int VS = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [VS*DW-1:0] s_vec = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [DW-1:0]    m_data;
    logic [IW-1:0]    m_index;
    logic             m_last;
    logic             argmax_valid;
    logic [IW-1:0]    argmax_idx;
    logic [DW-1:0]    argmax_val;

    int checks = 0;
    int errors = 0;

    vector_stream_tx #(
        .VEC_SIZE   (VS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_vec        (s_vec),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_index      (m_index),
        .m_last       (m_last),
        .argmax_valid (argmax_valid),
        .argmax_idx   (argmax_idx),
        .argmax_val   (argmax_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [31:0]  vec;
        int           exp_idx;
        int           exp_val;
        int           mode;
        logic [6:0]   pat;
    } vec_rec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input int e3, input int e2, input int e1, input int e0);
        return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    endfunction

    function automatic int el(input logic [31:0] v, input int k);
        return int'($signed(v[k*8 +: 8]));
    endfunction

    function automatic int sdata();
        return int'($signed(m_data));
    endfunction

    function automatic int sval();
        return int'($signed(argmax_val));
    endfunction

    // Reference: first index holding the largest signed element.
    task automatic ref_argmax(input logic [31:0] v, output int idx, output int val);
        int elems[$];
        for (int k = 0; k < VS; k++) elems.push_back(el(v, k));
        val = elems[0];
        idx = 0;
        foreach (elems[k]) begin
            if (elems[k] > val) begin
                val = elems[k];
                idx = k;
            end
        end
    endtask

    // mode 0: m_ready always 1; mode 1: pattern then 1; mode 2: random
    task automatic run_vector(input string nm, input logic [31:0] v, input int exp_idx,
                              input int exp_val, input int mode, input logic [6:0] pat);
        int n;
        int cyc;
        int bud;
        n = 0;
        cyc = 0;
        bud = 0;
        while (s_ready !== 1'b1 && bud < 50) begin
            tick();
            bud++;
        end
        chk({nm, " s_ready_idle"}, int'(s_ready), 1);
        s_valid = 1'b1;
        s_vec   = v;
        tick();
        s_valid = $urandom_range(0, 1);
        s_vec   = $urandom;
        while (n < VS && cyc < 200) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc < 7) ? pat[cyc] : 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            chk({nm, " m_valid_stream"}, int'(m_valid), 1);
            chk({nm, " s_ready_stream"}, int'(s_ready), 0);
            chk({nm, " pulse_early"}, int'(argmax_valid), 0);
            if (m_valid === 1'b1) begin
                chk({nm, " m_index"}, int'(m_index), n);
                chk({nm, " m_data"}, sdata(), el(v, n));
                chk({nm, " m_last"}, int'(m_last), (n == VS - 1) ? 1 : 0);
                if (m_ready) n++;
            end
            tick();
            cyc++;
        end
        if (n < VS) chk({nm, " transfers"}, n, VS);
        if (mode == 0) chk({nm, " latency"}, cyc, VS);
        s_valid = 1'b0;
        m_ready = 1'($urandom_range(0, 1));
        #1;
        chk({nm, " argmax_valid"}, int'(argmax_valid), 1);
        chk({nm, " m_valid_result"}, int'(m_valid), 0);
        chk({nm, " s_ready_result"}, int'(s_ready), 0);
        chk({nm, " argmax_idx"}, int'(argmax_idx), exp_idx);
        chk({nm, " argmax_val"}, sval(), exp_val);
        tick();
        m_ready = 1'b0;
        chk({nm, " pulse_end"}, int'(argmax_valid), 0);
        chk({nm, " s_ready_after"}, int'(s_ready), 1);
        chk({nm, " idx_hold"}, int'(argmax_idx), exp_idx);
        chk({nm, " val_hold"}, sval(), exp_val);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        vec_rec_t    tbl[5];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        int          ri;
        int          rv;

        tbl[0] = '{"basic",   pk(3, 127, -5, 10),          2, 127,  0, 7'b0};
        tbl[1] = '{"bpress",  pk(3, 127, -5, 10),          2, 127,  1, 7'b1101001};
        tbl[2] = '{"allneg",  pk(-128, -128, -128, -128),  0, -128, 0, 7'b0};
        tbl[3] = '{"ties",    pk(1, 9, 9, 5),              1, 9,    0, 7'b0};
        tbl[4] = '{"lastupd", pk(127, -128, 0, 0),         3, 127,  0, 7'b0};

        // Reset with random input activity
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_vec   = $urandom;
            tick();
            chk("rst m_valid", int'(m_valid), 0);
            chk("rst argmax_valid", int'(argmax_valid), 0);
            chk("rst argmax_idx", int'(argmax_idx), 0);
            chk("rst argmax_val", sval(), 0);
            chk("rst m_last", int'(m_last), 0);
        end
        s_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("post_rst s_ready", int'(s_ready), 1);
        chk("post_rst m_valid", int'(m_valid), 0);
        tick();
        chk("post_rst no_capture", int'(m_valid), 0);

        foreach (tbl[i])
            run_vector(tbl[i].name, tbl[i].vec, tbl[i].exp_idx, tbl[i].exp_val,
                       tbl[i].mode, tbl[i].pat);

        // Back-to-back: s_valid held, s_vec changes during A's stream
        a = pk(-1, 50, -7, 20);
        b = pk(9, 8, 7, 6);
        s_valid = 1'b1;
        s_vec   = a;
        tick();
        s_vec   = b;
        m_ready = 1'b1;
        for (int k = 0; k < VS; k++) begin
            chk("b2b s_ready_a", int'(s_ready), 0);
            chk("b2b m_index_a", int'(m_index), k);
            chk("b2b m_data_a", sdata(), el(a, k));
            tick();
        end
        chk("b2b argmax_valid_a", int'(argmax_valid), 1);
        chk("b2b s_ready_result", int'(s_ready), 0);
        chk("b2b idx_a", int'(argmax_idx), 2);
        chk("b2b val_a", sval(), 50);
        tick();
        chk("b2b s_ready_idle", int'(s_ready), 1);
        chk("b2b m_valid_idle", int'(m_valid), 0);
        tick();
        s_valid = 1'b0;
        for (int k = 0; k < VS; k++) begin
            chk("b2b m_valid_b", int'(m_valid), 1);
            chk("b2b m_index_b", int'(m_index), k);
            chk("b2b m_data_b", sdata(), el(b, k));
            tick();
        end
        chk("b2b argmax_valid_b", int'(argmax_valid), 1);
        chk("b2b idx_b", int'(argmax_idx), 3);
        chk("b2b val_b", sval(), 9);
        m_ready = 1'b0;
        tick();

        // Reset after two transfers
        v = pk(10, 20, 30, 40);
        s_valid = 1'b1;
        s_vec   = v;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        chk("midrst index_before", int'(m_index), 2);
        m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst m_valid_async", int'(m_valid), 0);
        chk("midrst argmax_valid", int'(argmax_valid), 0);
        for (int i = 0; i < 2; i++) begin
            m_ready = 1'b1;
            tick();
            chk("midrst no_pulse", int'(argmax_valid), 0);
            chk("midrst idx_cleared", int'(argmax_idx), 0);
        end
        m_ready = 1'b0;
        rst_n   = 1'b1;
        tick();
        run_vector("midrst_new", pk(4, 3, 2, 1), 3, 4, 0, 7'b0);

        // Randomised vectors with small-value bias to provoke ties
        for (int i = 0; i < 25; i++) begin
            for (int k = 0; k < VS; k++) begin
                if ($urandom_range(0, 1) == 1) v[k*8 +: 8] = 8'($urandom);
                else                           v[k*8 +: 8] = 8'($urandom_range(0, 2) - 1);
            end
            ref_argmax(v, ri, rv);
            run_vector($sformatf("rand%0d", i), v, ri, rv, 2, 7'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
